fifo_buffer: RTL and testbench
==============================

// Module: fifo_buffer
// PURPOSE
//  Single-clock first-in/first-out data buffer between a producer (we/datain) and a consumer (re/dataout).
//  Provides full/empty status for flow control and is the storage element behind the FIFO verification environment.
//  Read data is registered; all state updates occur on the rising edge of wclk.
// PARAMETERS
//  DATA_WIDTH  8   width of datain/dataout in bits
//  DEPTH       16  number of entries; must be a power of two >= 2
//  ADDR_WIDTH  $clog2(DEPTH)  derived; not overridden by users
// PORTS
//  wclk     in   1           the block's only clock, rising-edge
//  wreset   in   1           synchronous, active-low reset (sampled on wclk rising edge)
//  datain   in   DATA_WIDTH  write data, captured when a write is accepted
//  we       in   1           write request
//  re       in   1           read request
//  dataout  out  DATA_WIDTH  registered read data
//  full     out  1           high when DEPTH entries are stored
//  empty    out  1           high when no entries are stored
//  overflow  out 1           [FIFO_ERR_FLAGS_EN only] sticky: write attempted while full
//  underflow out 1           [FIFO_ERR_FLAGS_EN only] sticky: read attempted while empty
// BEHAVIOUR
//  - One clock, synchronous active-low reset: when wreset==0 at a wclk edge, the write/read pointers clear to 0,
//    dataout=0, full=0, empty=1, and overflow/underflow=0. Memory contents are not cleared.
//  - Reset asserted mid-operation discards all stored data on that edge. Requests on the same edge are ignored.
//  - Pointers are ADDR_WIDTH+1 bits; the low ADDR_WIDTH bits index memory; the MSB toggles on each wrap.
//  - empty = (wptr == rptr); full = (low bits equal) && (MSBs differ); both derived combinationally from pointer registers.
//  - Write accepted = we && !full: mem[wptr] <= datain, wptr increments; the entry becomes visible on the next cycle.
//  - Read accepted = re && !empty: dataout <= mem[rptr], rptr increments; data appears 1 cycle after the re edge.
//  - Rejected requests change no state. dataout holds its previous value when no read is accepted.
//  - Simultaneous we && re:
//    - neither full nor empty: both are accepted and the occupancy is unchanged.
//    - empty: only the write is accepted (no write-to-read bypass); empty deasserts next cycle.
//    - full: the read is accepted; the write is rejected because full is set at that edge.
//  - Occupancy never exceeds DEPTH. Pointer arithmetic is modulo 2^(ADDR_WIDTH+1).
//  - Data ordering is strictly FIFO across any number of wrap-arounds.
// CONFIGURATION
//  - FIFO_ERR_FLAGS_EN defined:
//    - ports overflow/underflow exist.
//    - overflow sets on the edge where we && full; underflow sets on the edge where re && empty.
//    - both flags hold until wreset==0.
//  - FIFO_ERR_FLAGS_EN undefined: the ports and their logic are absent; all other behaviour is identical.
// STRUCTURE
//  - Package fifo_pkg: DATA_WIDTH_DEF=8, DEPTH_DEF=16, and a typedef for the pointer width helper.
//  - Sub-module fifo_mem: DEPTH x DATA_WIDTH storage with one synchronous write port and a registered read port.
//  - fifo_buffer: pointer registers, full/empty logic, optional error flags.
// TESTING
//  - Reset: hold wreset=0 for 2 edges -> empty=1, full=0, dataout=0; release -> flags unchanged.
//  - Write then read: write 0x11..0x1A (10 writes) -> empty=0 after the first write.
//    Then assert re for 10 cycles -> dataout=0x11..0x1A in order, each 1 cycle after re; empty=1 after the last read.
//  - Full: 16 writes of 0x00..0x0F -> full=1. A 17th write of 0xFF is dropped; reading 16 entries returns 0x00..0x0F.
//  - Empty read: re=1 with the FIFO empty -> dataout holds its previous value and the pointers do not move.
//    With FIFO_ERR_FLAGS_EN -> underflow=1 until reset.
//  - Simultaneous: fill to 8 entries, then we=re=1 for 40 cycles -> occupancy stays 8.
//    Pointers wrap at least twice; output order matches input order.
//  - Mid-op reset: 5 writes, then wreset=0 for 1 edge -> empty=1; the next write/read pair returns the new data.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared defaults and pointer-width helper for the single-clock FIFO.
package fifo_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned DEPTH_DEF      = 16;

  // One extra MSB over the address bits distinguishes full from empty.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return 32'($clog2(depth)) + 32'd1;
  endfunction

  typedef logic [ptr_width(DEPTH_DEF)-1:0] ptr_def_t;

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: one synchronous write port and a registered read port.
// Only the read-data register is reset; the array itself keeps its contents.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned DEPTH      = DEPTH_DEF,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [DATA_WIDTH-1:0] rd_data_d;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Read data holds unless a read is accepted.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem_q[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/fifo_buffer.sv
// Single-clock FIFO: wrap-bit pointers, full/empty status, registered read data.
// Define FIFO_ERR_FLAGS_EN to add sticky overflow/underflow flags.
module fifo_buffer
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned DEPTH      = DEPTH_DEF
) (
  input  logic                  wclk,
  input  logic                  wreset,
  input  logic [DATA_WIDTH-1:0] datain,
  input  logic                  we,
  input  logic                  re,
  output logic [DATA_WIDTH-1:0] dataout,
  output logic                  full,
  output logic                  empty
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  // DEPTH must be a power of two >= 2 for the wrap-bit scheme to hold.
  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);
  localparam int unsigned PTR_WIDTH  = ptr_width(DEPTH);

  logic [PTR_WIDTH-1:0] wptr_q, wptr_d;
  logic [PTR_WIDTH-1:0] rptr_q, rptr_d;
  logic                 wr_acc;
  logic                 rd_acc;

  // Status comes straight from the pointer registers.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]) &&
                 (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]);

  // Requests are dropped on a reset edge.
  assign wr_acc = we && !full && wreset;
  assign rd_acc = re && !empty && wreset;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (wr_acc) begin
      wptr_d = wptr_q + PTR_WIDTH'(1);
    end
    if (rd_acc) begin
      rptr_d = rptr_q + PTR_WIDTH'(1);
    end
  end

  always_ff @(posedge wclk) begin
    if (!wreset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (wclk),
    .rst_n   (wreset),
    .wr_en   (wr_acc),
    .wr_addr (wptr_q[ADDR_WIDTH-1:0]),
    .wr_data (datain),
    .rd_en   (rd_acc),
    .rd_addr (rptr_q[ADDR_WIDTH-1:0]),
    .rd_data (dataout)
  );

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Sticky until reset.
  always_comb begin
    overflow_d  = overflow_q  | (we && full);
    underflow_d = underflow_q | (re && empty);
  end

  always_ff @(posedge wclk) begin
    if (!wreset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo_buffer.sv
// Directed and randomized checks of fifo_buffer against a queue-based model.
// Define FIFO_ERR_FLAGS_EN to also check overflow/underflow.
module tb_fifo_buffer;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;

  logic          wclk;
  logic          wreset;
  logic [DW-1:0] datain;
  logic          we;
  logic          re;
  logic [DW-1:0] dataout;
  logic          full;
  logic          empty;
`ifdef FIFO_ERR_FLAGS_EN
  logic          overflow;
  logic          underflow;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_dout;
  logic          exp_ovf;
  logic          exp_unf;

  fifo_buffer #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .wclk      (wclk),
    .wreset    (wreset),
    .datain    (datain),
    .we        (we),
    .re        (re),
    .dataout   (dataout),
    .full      (full),
    .empty     (empty)
`ifdef FIFO_ERR_FLAGS_EN
    ,
    .overflow  (overflow),
    .underflow (underflow)
`endif
  );

  initial begin
    wclk = 1'b0;
    forever #5 wclk = ~wclk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle, advance the model across the edge, then compare.
  task automatic cycle(input logic w, input logic r, input logic [DW-1:0] d, input logic rst_n_v);
    bit is_full, is_empty;
    we     = w;
    re     = r;
    datain = d;
    wreset = rst_n_v;
    @(posedge wclk);
    if (!rst_n_v) begin
      model_q.delete();
      exp_dout = '0;
      exp_ovf  = 1'b0;
      exp_unf  = 1'b0;
    end else begin
      is_full  = (model_q.size() == DEPTH);
      is_empty = (model_q.size() == 0);
      if (w && is_full)  exp_ovf = 1'b1;
      if (r && is_empty) exp_unf = 1'b1;
      if (r && !is_empty) exp_dout = model_q.pop_front();
      if (w && !is_full)  model_q.push_back(d);
    end
    #1;
    check("dataout", 32'(dataout), 32'(exp_dout));
    check("full", 32'(full), 32'(model_q.size() == DEPTH));
    check("empty", 32'(empty), 32'(model_q.size() == 0));
`ifdef FIFO_ERR_FLAGS_EN
    check("overflow", 32'(overflow), 32'(exp_ovf));
    check("underflow", 32'(underflow), 32'(exp_unf));
`endif
  endtask

  initial begin
    exp_dout = '0;
    exp_ovf  = 1'b0;
    exp_unf  = 1'b0;
    we = 1'b0; re = 1'b0; datain = '0; wreset = 1'b0;
    #2;

    // Reset for two edges, then release.
    cycle(1'b0, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b1);

    // Ten writes then ten reads.
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, DW'(8'h11 + i), 1'b1);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, '0, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b1);

    // Fill, dropped write, read/write on full, drain.
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, DW'(i), 1'b1);
    cycle(1'b1, 1'b0, 8'hFF, 1'b1);
    cycle(1'b1, 1'b1, 8'hEE, 1'b1);
    for (int i = 0; i < 17; i++) cycle(1'b0, 1'b1, '0, 1'b1);

    // Read while empty holds dataout; simultaneous we/re while empty takes only the write.
    cycle(1'b0, 1'b1, '0, 1'b1);
    cycle(1'b0, 1'b1, '0, 1'b1);
    cycle(1'b1, 1'b1, 8'h5A, 1'b1);
    cycle(1'b0, 1'b1, '0, 1'b1);

    // Steady occupancy of 8 while wrapping the pointers several times.
    cycle(1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, DW'(8'h80 + i), 1'b1);
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b1, DW'(8'h90 + i), 1'b1);
    check("occupancy", 32'(model_q.size()), 32'd8);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, '0, 1'b1);

    // Mid-operation reset discards data and ignores same-edge requests.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, DW'(8'h40 + i), 1'b1);
    cycle(1'b1, 1'b1, 8'h77, 1'b0);
    cycle(1'b1, 1'b0, 8'hA5, 1'b1);
    cycle(1'b0, 1'b1, '0, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b1);

    // Randomized traffic with occasional resets; bias toward filling or draining in phases.
    for (int i = 0; i < 3000; i++) begin
      logic w, r, rs;
      int unsigned phase;
      phase = (i / 200) % 3;
      w  = (phase == 0) ? ($urandom_range(0, 3) != 0) :
           (phase == 1) ? ($urandom_range(0, 3) == 0) : 1'($urandom);
      r  = (phase == 1) ? ($urandom_range(0, 3) != 0) :
           (phase == 0) ? ($urandom_range(0, 3) == 0) : 1'($urandom);
      rs = ($urandom_range(0, 255) != 0);
      cycle(w, r, DW'($urandom), rs);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
